// File: rtl/ss_rvc_decode.sv
// rtl/ss_rvc_decode.sv - ss_rvc decode stage with 2-entry skid-buffered output
//
// Decodes LOAD / STORE / OP-IMM / OP instructions into register indices, a
// sign-extended immediate and ALU / memory controls. Everything else is
// flagged illegal but still flows downstream in order.
//
// Ports:
//   clk_i, rst_n_i        core clock, asynchronous active-low reset
//   flush_i               synchronous flush: drops both buffered entries and the input
//   inst_valid_i/ready_o  fetch handshake; inst_i / inst_pc_i are the payload
//   dec_valid_o/ready_i   execute handshake; dec_* are the registered payload
//   illegal_cnt_o         saturating count of accepted illegal encodings
module ss_rvc_decode #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  inst_pc_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [XLEN-1:0]  dec_pc_o,
    output logic [4:0]       dec_rs1_o,
    output logic [4:0]       dec_rs2_o,
    output logic [4:0]       dec_rd_o,
    output logic [XLEN-1:0]  dec_imm_o,
    output logic [2:0]       dec_alu_op_o,
    output logic             dec_sub_sra_o,
    output logic             dec_alu_src_imm_o,
    output logic             dec_reg_wr_o,
    output logic             dec_mem_rd_o,
    output logic             dec_mem_wr_o,
    output logic [2:0]       dec_mem_size_o,
    output logic             dec_illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      alu_op;
        logic            sub_sra;
        logic            alu_src_imm;
        logic            reg_wr;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      mem_size;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ---------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7_zero;
    logic            f7_alt;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic            legal;
    entry_t          dec;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign f7_zero = (inst_i[31:25] == 7'b0000000);
    assign f7_alt  = (inst_i[31:25] == 7'b0100000);
    assign imm_i   = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s   = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};

    always_comb begin
        dec     = '0;
        legal   = 1'b0;
        dec.pc  = inst_pc_i;
        dec.rs1 = inst_i[19:15];
        dec.rs2 = inst_i[24:20];
        dec.rd  = inst_i[11:7];
        case (opcode)
            OPC_LOAD: begin
                // 011, 110 and 111 are not defined load widths
                legal           = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.mem_rd      = 1'b1;
                dec.reg_wr      = 1'b1;
                dec.mem_size    = funct3;
            end
            OPC_STORE: begin
                legal           = !funct3[2] && (funct3[1:0] != 2'b11);
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_wr      = 1'b1;
                dec.mem_size    = funct3;
            end
            OPC_OP_IMM: begin
                dec.alu_op      = funct3;
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_wr      = 1'b1;
                case (funct3)
                    3'b001:  legal = f7_zero;
                    3'b101: begin
                        legal       = f7_zero || f7_alt;
                        dec.sub_sra = inst_i[30];
                    end
                    default: legal = 1'b1;
                endcase
            end
            OPC_OP: begin
                dec.alu_op  = funct3;
                dec.reg_wr  = 1'b1;
                dec.sub_sra = inst_i[30];
                legal       = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries must never cause architectural side effects
        dec.reg_wr  = dec.reg_wr && legal && (dec.rd != 5'd0);
        dec.mem_rd  = dec.mem_rd && legal;
        dec.mem_wr  = dec.mem_wr && legal;
        dec.illegal = !legal;
    end

    // ---------------------------------------------------------------
    // Output register (or) + skid register (sk)
    // ---------------------------------------------------------------
    entry_t           or_q, or_d, sk_q, sk_d;
    logic             or_valid_q, or_valid_d;
    logic             sk_valid_q, sk_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             pop;

    // Ready depends only on skid occupancy, so dec_ready_i never reaches inst_ready_o
    assign inst_ready_o = !sk_valid_q;
    assign accept       = inst_valid_i && !sk_valid_q && !flush_i;
    assign pop          = or_valid_q && dec_ready_i;

    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        cnt_d      = cnt_q;
        if (flush_i) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (!or_valid_q || pop) begin
            if (sk_valid_q) begin
                // Older skid entry moves up first to preserve order
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = accept;
                if (accept) begin
                    sk_d = dec;
                end
            end else begin
                or_valid_d = accept;
                if (accept) begin
                    or_d = dec;
                end
            end
        end else if (accept) begin
            sk_d       = dec;
            sk_valid_d = 1'b1;
        end
        if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign dec_valid_o       = or_valid_q;
    assign dec_pc_o          = or_q.pc;
    assign dec_rs1_o         = or_q.rs1;
    assign dec_rs2_o         = or_q.rs2;
    assign dec_rd_o          = or_q.rd;
    assign dec_imm_o         = or_q.imm;
    assign dec_alu_op_o      = or_q.alu_op;
    assign dec_sub_sra_o     = or_q.sub_sra;
    assign dec_alu_src_imm_o = or_q.alu_src_imm;
    assign dec_reg_wr_o      = or_q.reg_wr;
    assign dec_mem_rd_o      = or_q.mem_rd;
    assign dec_mem_wr_o      = or_q.mem_wr;
    assign dec_mem_size_o    = or_q.mem_size;
    assign dec_illegal_o     = or_q.illegal;
    assign illegal_cnt_o     = cnt_q;

endmodule

// File: tb/tb_ss_rvc_decode.sv
// tb/tb_ss_rvc_decode.sv - self-checking bench for ss_rvc_decode
module tb_ss_rvc_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm;
    logic [2:0]  dec_alu_op;
    logic        dec_sub_sra, dec_alu_src_imm, dec_reg_wr, dec_mem_rd, dec_mem_wr;
    logic [2:0]  dec_mem_size;
    logic        dec_illegal;
    logic [7:0]  illegal_cnt;

    always #5 clk = ~clk;

    ss_rvc_decode #(.XLEN(32), .CNT_W(8)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .flush_i          (flush),
        .inst_valid_i     (inst_valid),
        .inst_ready_o     (inst_ready),
        .inst_i           (inst),
        .inst_pc_i        (inst_pc),
        .dec_valid_o      (dec_valid),
        .dec_ready_i      (dec_ready),
        .dec_pc_o         (dec_pc),
        .dec_rs1_o        (dec_rs1),
        .dec_rs2_o        (dec_rs2),
        .dec_rd_o         (dec_rd),
        .dec_imm_o        (dec_imm),
        .dec_alu_op_o     (dec_alu_op),
        .dec_sub_sra_o    (dec_sub_sra),
        .dec_alu_src_imm_o(dec_alu_src_imm),
        .dec_reg_wr_o     (dec_reg_wr),
        .dec_mem_rd_o     (dec_mem_rd),
        .dec_mem_wr_o     (dec_mem_wr),
        .dec_mem_size_o   (dec_mem_size),
        .dec_illegal_o    (dec_illegal),
        .illegal_cnt_o    (illegal_cnt)
    );

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    logic [90:0] q[$];
    logic [7:0]  cnt_m = 8'd0;

    // Fields of an illegal entry that carry a defined value
    localparam logic [90:0] MASK_ILL = {{47{1'b1}}, {32{1'b0}}, 5'b00000, 3'b111, 3'b000, 1'b1};

    function automatic logic [90:0] actual();
        return {dec_pc, dec_rs1, dec_rs2, dec_rd, dec_imm, dec_alu_op, dec_sub_sra,
                dec_alu_src_imm, dec_reg_wr, dec_mem_rd, dec_mem_wr, dec_mem_size, dec_illegal};
    endfunction

    // Reference decode straight from the instruction-set rules
    function automatic logic [90:0] model(input logic [31:0] w, input logic [31:0] pc);
        logic [6:0]  op = w[6:0];
        logic [2:0]  f3 = w[14:12];
        logic [6:0]  f7 = w[31:25];
        logic        ok = 1'b0, rw = 1'b0, mr = 1'b0, mw = 1'b0, si = 1'b0, ss = 1'b0;
        logic [2:0]  aop = 3'd0, msz = 3'd0;
        logic [31:0] imm = 32'd0;
        int          iv;
        if (op == 7'h03) begin
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            iv = $signed(w[31:20]); imm = iv;
            si = 1; mr = 1; rw = 1; msz = f3;
        end else if (op == 7'h23) begin
            ok = f3 inside {3'd0, 3'd1, 3'd2};
            iv = $signed({w[31:25], w[11:7]}); imm = iv;
            si = 1; mw = 1; msz = f3;
        end else if (op == 7'h13) begin
            aop = f3; iv = $signed(w[31:20]); imm = iv; si = 1; rw = 1;
            if (f3 == 3'd1)      ok = (f7 == 7'd0);
            else if (f3 == 3'd5) begin ok = (f7 == 7'd0) || (f7 == 7'd32); ss = w[30]; end
            else                 ok = 1;
        end else if (op == 7'h33) begin
            aop = f3; rw = 1; ss = w[30];
            ok = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
        end
        if (!ok) begin rw = 0; mr = 0; mw = 0; end
        if (w[11:7] == 5'd0) rw = 0;
        return {pc, w[19:15], w[24:20], w[11:7], imm, aop, ss, si, rw, mr, mw, msz, !ok};
    endfunction

    function automatic logic [31:0] gen_inst(input bit allow_illegal);
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [31:0] r = $urandom;
        int k = allow_illegal ? $urandom_range(0, 9) : $urandom_range(0, 7);
        case (k % 4)
            0: op = 7'h03;
            1: op = 7'h23;
            2: op = 7'h13;
            default: op = 7'h33;
        endcase
        if (k == 9) return $urandom;
        if (k == 8) op = {r[6:2], 2'b01};
        case ($urandom_range(0, 2))
            0: f7 = 7'd0;
            1: f7 = 7'd32;
            default: f7 = r[31:25];
        endcase
        if (!allow_illegal) begin
            f7 = (op == 7'h03 || op == 7'h23) ? r[31:25] : 7'd0;
            r[14:12] = (op == 7'h03) ? 3'd2 : (op == 7'h23) ? 3'd1 : r[14:12];
        end
        return {f7, r[24:20], r[19:15], r[14:12], r[11:7], op};
    endfunction

    // One clock: drive inputs, check at negedge, advance model at posedge
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, output logic acc);
        logic [90:0] e, m;
        inst_valid = v; inst = ins; inst_pc = pc; dec_ready = rdy; flush = fl;
        @(negedge clk);
        acc = v && (q.size() < 2) && !fl;
        total++;
        if (inst_ready !== (q.size() < 2)) begin
            bad++; $display("FAIL inst_ready: got %b want %b", inst_ready, q.size() < 2);
        end
        total++;
        if (dec_valid !== (q.size() > 0)) begin
            bad++; $display("FAIL dec_valid: got %b want %b", dec_valid, q.size() > 0);
        end
        total++;
        if (illegal_cnt !== cnt_m) begin
            bad++; $display("FAIL illegal_cnt: got %0d want %0d", illegal_cnt, cnt_m);
        end
        if (q.size() > 0) begin
            e = q[0];
            m = e[0] ? MASK_ILL : {91{1'b1}};
            total++;
            if ((actual() & m) !== (e & m)) begin
                bad++; $display("FAIL entry: got %h want %h", actual() & m, e & m);
            end
        end
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && rdy) begin void'(q.pop_front()); npop++; end
            if (acc) begin
                e = model(ins, pc);
                q.push_back(e);
                if (e[0] && cnt_m != 8'hFF) cnt_m++;
            end
        end
        #1;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 10 && q.size() > 0; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
        total++;
        if (q.size() != 0 || dec_valid !== 1'b0) begin
            bad++; $display("FAIL drain: dec_valid=%b left=%0d want 0", dec_valid, q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inst_valid = 0; inst = 0; inst_pc = 0; dec_ready = 0; flush = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({dec_valid, inst_ready, illegal_cnt} !== {1'b0, 1'b1, 8'd0}) begin
            bad++; $display("FAIL reset_ctrl: got %b want %b", {dec_valid, inst_ready, illegal_cnt}, 10'b01_00000000);
        end
        total++;
        if (actual() !== 91'd0) begin
            bad++; $display("FAIL reset_data: got %h want 0", actual());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic a;
        cyc(1'b1, 32'hFFB10093, 32'h100, 1'b1, 1'b0, a);
        total++;
        if ({dec_valid, dec_rs1, dec_rd, dec_imm, dec_alu_op, dec_alu_src_imm, dec_reg_wr, dec_illegal}
            !== {1'b1, 5'd2, 5'd1, 32'hFFFFFFFB, 3'b000, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL addi: rs1=%0d rd=%0d imm=%h op=%b si=%b rw=%b ill=%b", dec_rs1, dec_rd,
                            dec_imm, dec_alu_op, dec_alu_src_imm, dec_reg_wr, dec_illegal);
        end
        cyc(1'b1, 32'h00532423, 32'h104, 1'b1, 1'b0, a);
        total++;
        if ({dec_rs1, dec_rs2, dec_imm, dec_mem_wr, dec_mem_size, dec_reg_wr}
            !== {5'd6, 5'd5, 32'd8, 1'b1, 3'b010, 1'b0}) begin
            bad++; $display("FAIL sw: rs1=%0d rs2=%0d imm=%h mw=%b sz=%b rw=%b want 6 5 8 1 010 0",
                            dec_rs1, dec_rs2, dec_imm, dec_mem_wr, dec_mem_size, dec_reg_wr);
        end
        cyc(1'b1, 32'h402081B3, 32'h108, 1'b1, 1'b0, a);
        total++;
        if ({dec_alu_op, dec_sub_sra, dec_alu_src_imm, dec_rd} !== {3'b000, 1'b1, 1'b0, 5'd3}) begin
            bad++; $display("FAIL sub: op=%b ss=%b si=%b rd=%0d want 000 1 0 3",
                            dec_alu_op, dec_sub_sra, dec_alu_src_imm, dec_rd);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[4];
        logic a;
        int idx = 0;
        int p0 = npop;
        for (int i = 0; i < 4; i++) ins[i] = gen_inst(1'b0);
        for (int c = 0; c < 30 && idx < 4; c++) begin
            cyc(1'b1, ins[idx], 32'h200 + 4 * idx, (c >= 3), 1'b0, a);
            if (a) idx++;
            if (c == 1) begin
                total++;
                if (inst_ready !== 1'b0) begin
                    bad++; $display("FAIL b2b_stall_ready: got %b want 0", inst_ready);
                end
            end
        end
        drain();
        total++;
        if (npop - p0 != 4 || idx != 4) begin
            bad++; $display("FAIL b2b_count: got %0d popped %0d accepted want 4", npop - p0, idx);
        end
    endtask

    task automatic test_flush();
        logic a;
        logic [7:0] c0;
        cyc(1'b1, gen_inst(1'b0), 32'h300, 1'b0, 1'b0, a);
        cyc(1'b1, gen_inst(1'b0), 32'h304, 1'b0, 1'b0, a);
        c0 = cnt_m;
        cyc(1'b1, 32'h00000000, 32'h308, 1'b0, 1'b1, a);
        total++;
        if ({dec_valid, inst_ready, illegal_cnt} !== {1'b0, 1'b1, c0}) begin
            bad++; $display("FAIL flush: valid=%b ready=%b cnt=%0d want 0 1 %0d", dec_valid, inst_ready, illegal_cnt, c0);
        end
        drain();
    endtask

    task automatic test_random();
        logic a;
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) != 0, gen_inst(1'b1), $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 39) == 0, a);
        drain();
    endtask

    task automatic test_illegal_sat();
        logic a;
        int n = 0;
        logic [31:0] r;
        cyc(1'b1, 32'h00000000, 32'h400, 1'b1, 1'b0, a);
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            cyc(1'b1, {r[31:2], 2'b01}, 32'h404 + 4 * i, 1'b1, 1'b0, a);
            if (a) n++;
        end
        drain();
        total++;
        if (illegal_cnt !== 8'd255 || n != 300) begin
            bad++; $display("FAIL illegal_sat: cnt=%0d accepts=%0d want 255 300", illegal_cnt, n);
        end
    endtask

    task automatic test_reset_midstream();
        logic a;
        cyc(1'b1, gen_inst(1'b0), 32'h500, 1'b0, 1'b0, a);
        cyc(1'b1, gen_inst(1'b0), 32'h504, 1'b0, 1'b0, a);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({dec_valid, inst_ready, illegal_cnt} !== {1'b0, 1'b1, 8'd0} || actual() !== 91'd0) begin
            bad++; $display("FAIL async_reset: valid=%b ready=%b cnt=%0d data=%h want 0 1 0 0",
                            dec_valid, inst_ready, illegal_cnt, actual());
        end
        q.delete(); cnt_m = 8'd0; inst_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 32'hFFB10093, 32'h600, 1'b0, 1'b0, a);
        total++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h600}) begin
            bad++; $display("FAIL post_reset_latency: valid=%b pc=%h want 1 600", dec_valid, dec_pc);
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_illegal_sat();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
